forwarding_hazard_unit: RTL and testbench

//  Producer side of the EX-stage operand-forwarding interface: tracks destination tags of in-flight instructions,

---
 rtl/mips_pkg.sv | 14 +
 rtl/fwd_select.sv | 17 +
 rtl/forwarding_hazard_unit.sv | 68 ++++++
 tb/tb_forwarding_hazard_unit.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared forwarding-select codes, register-index width and shadow-slot type.
package mips_pkg;
  localparam int REG_ADDR_W = 5;
  localparam logic [1:0] FWD_REG    = 2'b00;
  localparam logic [1:0] FWD_MEM_WB = 2'b01;
  localparam logic [1:0] FWD_EX_MEM = 2'b10;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dest;
    logic                  reg_write;
    logic                  mem_read;
  } slot_t;
endpackage

// File: rtl/fwd_select.sv
// fwd_select: picks the forwarding source for one operand, youngest producer first.
module fwd_select
  import mips_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] src_i,
  input  logic                  uses_i,
  input  slot_t                 ex_slot_i,
  input  slot_t                 mem_slot_i,
  output logic [1:0]            sel_o
);
  logic live, ex_hit, mem_hit;
  assign live    = uses_i && src_i != REG_ZERO;
  // a load in EX cannot forward yet; that case stalls instead
  assign ex_hit  = ex_slot_i.valid && ex_slot_i.reg_write && !ex_slot_i.mem_read && ex_slot_i.dest == src_i;
  assign mem_hit = mem_slot_i.valid && mem_slot_i.reg_write && mem_slot_i.dest == src_i;
  always_comb sel_o = (live && ex_hit) ? FWD_EX_MEM : (live && mem_hit) ? FWD_MEM_WB : FWD_REG;
endmodule

// File: rtl/forwarding_hazard_unit.sv
// forwarding_hazard_unit: registered EX forwarding selects and load-use stall detection.
// Define HAZARD_STATS_EN to add the saturating stall_count output.
module forwarding_hazard_unit
  import mips_pkg::*;
`ifdef HAZARD_STATS_EN
#(
  parameter int STAT_W = 16
)
`endif
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic [1:0]            Forward_A,
  output logic [1:0]            Forward_B,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  id_ex_bubble
`ifdef HAZARD_STATS_EN
  ,output logic [STAT_W-1:0]    stall_count
`endif
);
  slot_t ex_q, ex_d, mem_q;
  logic [1:0] fa_q, fb_q, sel_a, sel_b;
  logic stall, hold, bubble;
  fwd_select u_fwd_a (.src_i(id_rs), .uses_i(id_uses_rs), .ex_slot_i(ex_q), .mem_slot_i(mem_q), .sel_o(sel_a));
  fwd_select u_fwd_b (.src_i(id_rt), .uses_i(id_uses_rt), .ex_slot_i(ex_q), .mem_slot_i(mem_q), .sel_o(sel_b));
  assign stall = ex_q.valid && ex_q.mem_read && ex_q.dest != REG_ZERO &&
                 ((id_uses_rs && id_rs == ex_q.dest) || (id_uses_rt && id_rt == ex_q.dest));
  // flush kills the consumer, so there is nothing left to hold
  assign hold         = stall && !flush;
  assign bubble       = stall || flush;
  assign pc_write     = !hold;
  assign if_id_write  = !hold;
  assign id_ex_bubble = bubble;
  assign Forward_A    = fa_q;
  assign Forward_B    = fb_q;
  always_comb ex_d = bubble ? '0 : '{valid: 1'b1, dest: id_dest, reg_write: id_reg_write, mem_read: id_mem_read};
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      fa_q  <= FWD_REG;
      fb_q  <= FWD_REG;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      fa_q  <= bubble ? FWD_REG : sel_a;
      fb_q  <= bubble ? FWD_REG : sel_b;
    end
  end
`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (hold && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign stall_count = cnt_q;
`endif
endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// tb_forwarding_hazard_unit: directed and random checks against an instruction-history model.
module tb_forwarding_hazard_unit;
  logic clk = 1'b0, reset = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, id_dest = '0;
  logic id_uses_rs = 1'b0, id_uses_rt = 1'b0, id_reg_write = 1'b0, id_mem_read = 1'b0, flush = 1'b0;
  logic [1:0] Forward_A, Forward_B;
  logic pc_write, if_id_write, id_ex_bubble;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_count;
  logic [15:0] cnt_m = '0;
`endif
  int vectors = 0, miscompares = 0;
  logic last_pcw, last_bub;

  forwarding_hazard_unit dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .id_dest(id_dest), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .flush(flush), .Forward_A(Forward_A), .Forward_B(Forward_B),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble)
`ifdef HAZARD_STATS_EN
    , .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {bit v; int d; bit rw; bit mr;} ins_t;
  ins_t hist[2];  // hist[0] = instruction now in EX, hist[1] = in MEM

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int fwd_of(input int src, input bit uses);
    if (!uses || src == 0) return 0;
    for (int i = 0; i < 2; i++)
      if (hist[i].v && hist[i].rw && hist[i].d == src) return (i == 0) ? 2 : 1;
    return 0;
  endfunction

  function automatic bit load_use();
    return hist[0].v && hist[0].mr && hist[0].d != 0 &&
           ((id_uses_rs && id_rs == hist[0].d) || (id_uses_rt && id_rt == hist[0].d));
  endfunction

  task automatic drive(input int rs, input int rt, input bit urs, input bit urt,
                       input int dest, input bit rw, input bit mr, input bit fl);
    id_rs = rs[4:0]; id_rt = rt[4:0]; id_uses_rs = urs; id_uses_rt = urt;
    id_dest = dest[4:0]; id_reg_write = rw; id_mem_read = mr; flush = fl;
  endtask

  task automatic do_reset();
    flush = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    hist[0] = '{0, 0, 0, 0}; hist[1] = '{0, 0, 0, 0};
    chk("rst_fwd_a", Forward_A, 0);
    chk("rst_fwd_b", Forward_B, 0);
    chk("rst_pc_write", pc_write, 1);
    chk("rst_if_id_write", if_id_write, 1);
    chk("rst_bubble", id_ex_bubble, 0);
`ifdef HAZARD_STATS_EN
    cnt_m = '0;
    chk("rst_stall_count", stall_count, 0);
`endif
  endtask

  task automatic ins(input int rs, input int rt, input bit urs, input bit urt,
                     input int dest, input bit rw, input bit mr, input bit fl);
    bit haz, hold, bub;
    int nfa, nfb;
    drive(rs, rt, urs, urt, dest, rw, mr, fl);
    #1;
    haz = load_use(); hold = haz && !fl; bub = haz || fl;
    last_pcw = pc_write; last_bub = id_ex_bubble;
    chk("pc_write", pc_write, !hold);
    chk("if_id_write", if_id_write, !hold);
    chk("bubble", id_ex_bubble, bub);
    nfa = bub ? 0 : fwd_of(rs, urs);
    nfb = bub ? 0 : fwd_of(rt, urt);
`ifdef HAZARD_STATS_EN
    if (hold && cnt_m != 16'hFFFF) cnt_m++;
`endif
    @(posedge clk); #1;
    hist[1] = hist[0];
    hist[0] = bub ? '{0, 0, 0, 0} : '{1, dest, rw, mr};
    chk("fwd_a", Forward_A, nfa);
    chk("fwd_b", Forward_B, nfb);
`ifdef HAZARD_STATS_EN
    chk("stall_count", stall_count, cnt_m);
`endif
  endtask

  initial begin
    hist[0] = '{0, 0, 0, 0}; hist[1] = '{0, 0, 0, 0};
    @(posedge clk); #1;
    do_reset();
    // add $3,$1,$2 ; add $4,$3,$5
    ins(1, 2, 1, 1, 3, 1, 0, 0);
    ins(3, 5, 1, 1, 4, 1, 0, 0);
    chk("ex_fwd_a", Forward_A, 2); chk("ex_fwd_b", Forward_B, 0); chk("ex_no_stall", last_pcw, 1);
    // add $3 ; nop ; sub $6,$7,$3
    do_reset();
    ins(1, 2, 1, 1, 3, 1, 0, 0);
    ins(0, 0, 0, 0, 0, 0, 0, 0);
    ins(7, 3, 1, 1, 6, 1, 0, 0);
    chk("mem_fwd_a", Forward_A, 0); chk("mem_fwd_b", Forward_B, 1);
    // $3 written twice: youngest wins
    do_reset();
    ins(1, 2, 1, 1, 3, 1, 0, 0);
    ins(1, 2, 1, 1, 3, 1, 0, 0);
    ins(7, 3, 1, 1, 6, 1, 0, 0);
    chk("youngest_fwd_b", Forward_B, 2);
    // lw $2 ; add $8,$2,$2
    do_reset();
    ins(1, 0, 1, 0, 2, 1, 1, 0);
    ins(2, 2, 1, 1, 8, 1, 0, 0);
    chk("lu_pc_hold", last_pcw, 0); chk("lu_bubble", last_bub, 1); chk("lu_fwd_a0", Forward_A, 0);
    ins(2, 2, 1, 1, 8, 1, 0, 0);
    chk("lu_fwd_a", Forward_A, 1); chk("lu_fwd_b", Forward_B, 1); chk("lu_once", last_pcw, 1);
    // $0 producer
    do_reset();
    ins(1, 2, 1, 1, 0, 1, 0, 0);
    ins(0, 0, 1, 1, 9, 1, 0, 0);
    chk("zero_fwd_a", Forward_A, 0); chk("zero_fwd_b", Forward_B, 0); chk("zero_no_stall", last_pcw, 1);
    // lw $2 then flushed consumer
    do_reset();
    ins(1, 0, 1, 0, 2, 1, 1, 0);
    ins(2, 2, 1, 1, 8, 1, 0, 1);
    chk("flush_pc_write", last_pcw, 1); chk("flush_bubble", last_bub, 1); chk("flush_fwd_a", Forward_A, 0);
    // reset during a load-use stall
    do_reset();
    ins(1, 0, 1, 0, 2, 1, 1, 0);
    drive(2, 2, 1, 1, 8, 1, 0, 0);
    #1;
    chk("mid_stall_hold", pc_write, 0);
    do_reset();
    ins(2, 2, 1, 1, 8, 1, 0, 0);
    chk("post_rst_fwd_a", Forward_A, 0); chk("post_rst_pcw", last_pcw, 1);
`ifdef HAZARD_STATS_EN
    do_reset();
    for (int k = 0; k < 3; k++) begin
      ins(1, 0, 1, 0, 2, 1, 1, 0);
      ins(2, 4, 1, 1, 8, 1, 0, 0);
      ins(2, 4, 1, 1, 8, 1, 0, 0);
    end
    chk("three_stalls", stall_count, 3);
`endif
    // random traffic over a small register window to provoke matches
    do_reset();
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      ins($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 5), $urandom_range(0, 1), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 7) == 0));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
